fpga_msg_arbiter: RTL and testbench

Shares the single FPGA→PC message path (the write port of `xb_rd_fifo`, i.e. `fpga_msg`/`fpga_msg_valid`) between `N_REQ` application requesters in the `CLK` domain. Uses round-robin arbitration with packet locking, so a multi-word message from one requester is never interleaved with another's. Honours the FIFO's back-pressure and records FIFO overflow as a sticky error. Sits between the `application` submodules and `xb_rd_fifo` in `main`.

---
 rtl/fpga_msg_pkg.sv | 22 ++
 rtl/fpga_msg_arbiter_rr_pick.sv | 33 +++
 rtl/fpga_msg_arbiter.sv | 134 +++++++++++++
 tb/tb_fpga_msg_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_msg_pkg.sv
// Shared types and helpers for the FPGA-to-PC message arbiter and its picker.
// Width helpers are constant functions so they can size ports and registers.
package fpga_msg_pkg;

    localparam int N_ARB_STATE = 2;

    // Ceiling log2 with a floor of 1, so a 2-entry space still gets a 1-bit index.
    function automatic int log2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

    typedef enum logic [log2(N_ARB_STATE)-1:0] {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fpga_msg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from last+1, wrapping modulo N_REQ.
module rr_pick
    import fpga_msg_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDW = log2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last,
    output logic             any,
    output logic [IDW-1:0]   winner
);

    logic             found;
    logic [IDW-1:0]   idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = IDW'((int'(last) + i) % N_REQ);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/fpga_msg_arbiter.sv
// Round-robin, packet-locked arbiter sharing the xb_rd_fifo write port
// between N_REQ application requesters, with sticky FIFO overflow capture.
module fpga_msg_arbiter
    import fpga_msg_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 16,
    parameter int DELAY     = 1,
    localparam int IDW      = log2(N_REQ)
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0]       req_last,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ack,
    output logic [WIDTH-1:0]       fpga_msg,
    output logic                   fpga_msg_valid,
    input  logic                   fpga_msg_full,
    input  logic                   fpga_msg_overflow,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy,
    output logic                   overflow_err
);

    localparam int BW = log2(MAX_BURST);

    if (N_REQ < 2 || N_REQ > 8 || MAX_BURST < 2 ||
        (MAX_BURST & (MAX_BURST - 1)) != 0 || DELAY < 0) begin : g_param_check
        $error("fpga_msg_arbiter: illegal parameter set");
    end

    arb_state_e         state_q, state_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [IDW-1:0]     last_q, last_d;
    logic [BW-1:0]      burst_q, burst_d;
    logic [WIDTH-1:0]   msg_q, msg_d;
    logic               msg_valid_q, msg_valid_d;
    logic               ovf_q, ovf_d;

    logic               pick_any;
    logic [IDW-1:0]     pick_winner;
    logic               ack_fire;
    logic               release_now;
    logic [WIDTH-1:0]   req_words [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_words[g] = req_data[g*WIDTH +: WIDTH];
    end

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (req_valid),
        .last   (last_q),
        .any    (pick_any),
        .winner (pick_winner)
    );

    // Handshake: a word moves from requester i when req_valid[i] and req_ack[i]
    // are both high in the same cycle; req_ack is combinational and only the
    // locked grantee is ever acked. A grantee may withdraw valid without losing
    // its lock, and sees no ack while fpga_msg_full is high.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            last_q      <= IDW'(N_REQ - 1);
            burst_q     <= '0;
            msg_q       <= '0;
            msg_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            burst_q     <= burst_d;
            msg_q       <= msg_d;
            msg_valid_q <= msg_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign release_now = ack_fire &&
                         (req_last[grant_q] || burst_q == BW'(MAX_BURST - 1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        burst_d = burst_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_winner;
                    burst_d = '0;
                    state_d = ARB_XFER;
                end
            end
            ARB_XFER: begin
                if (ack_fire) begin
                    burst_d = burst_q + 1'b1;
                end
                if (release_now) begin
                    last_d  = grant_q;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        req_ack     = '0;
        ack_fire    = 1'b0;
        msg_d       = msg_q;
        msg_valid_d = 1'b0;
        ovf_d       = ovf_q | fpga_msg_overflow;
        if (state_q == ARB_XFER && req_valid[grant_q] && !fpga_msg_full) begin
            ack_fire         = 1'b1;
            req_ack[grant_q] = 1'b1;
            msg_d            = req_words[grant_q];
            msg_valid_d      = 1'b1;
        end
    end

    assign fpga_msg       = msg_q;
    assign fpga_msg_valid = msg_valid_q;
    assign grant_id       = grant_q;
    assign busy           = (state_q == ARB_XFER);
    assign overflow_err   = ovf_q;

endmodule

// File: tb/tb_fpga_msg_arbiter.sv
// Directed bench for fpga_msg_arbiter: cycle tables for arbitration order and
// locking, plus hand sequences for burst limit, back-pressure, overflow, reset.
module tb_fpga_msg_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [W-1:0]   lane [N];
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ack;
    logic [W-1:0]   fpga_msg;
    logic           fpga_msg_valid;
    logic           fpga_msg_full;
    logic           fpga_msg_overflow;
    logic [1:0]     grant_id;
    logic           busy;
    logic           overflow_err;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    int w3;
    int done0;
    int n3_before0;
    int acks_total;
    int acks_in_full;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] last;
        logic         full;
        logic [W-1:0] data;
        logic [N-1:0] e_ack;
        logic         e_mv;
        logic [W-1:0] e_msg;
        logic [1:0]   e_grant;
        logic         e_busy;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_lane
        assign req_data[g*W +: W] = lane[g];
    end

    fpga_msg_arbiter #(
        .N_REQ     (N),
        .WIDTH     (W),
        .MAX_BURST (16),
        .DELAY     (1)
    ) dut (
        .CLK               (clk),
        .RESET             (rst_n),
        .req_valid         (req_valid),
        .req_last          (req_last),
        .req_data          (req_data),
        .req_ack           (req_ack),
        .fpga_msg          (fpga_msg),
        .fpga_msg_valid    (fpga_msg_valid),
        .fpga_msg_full     (fpga_msg_full),
        .fpga_msg_overflow (fpga_msg_overflow),
        .grant_id          (grant_id),
        .busy              (busy),
        .overflow_err      (overflow_err)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [N-1:0] v, input logic [N-1:0] l, input logic f,
                                input logic [W-1:0] d, input logic [N-1:0] ea, input logic emv,
                                input logic [W-1:0] em, input logic [1:0] eg, input logic eb);
        vec_t t;
        t.valid = v; t.last = l; t.full = f; t.data = d;
        t.e_ack = ea; t.e_mv = emv; t.e_msg = em; t.e_grant = eg; t.e_busy = eb;
        vecs.push_back(t);
    endfunction

    task automatic clear_inputs();
        req_valid = '0;
        req_last = '0;
        fpga_msg_full = 1'b0;
        fpga_msg_overflow = 1'b0;
        for (int i = 0; i < N; i++) lane[i] = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Each lane carries the table word tagged with its requester number in bits 27:24.
    task automatic run_vecs(input string tag);
        foreach (vecs[k]) begin
            @(negedge clk);
            req_valid = vecs[k].valid;
            req_last = vecs[k].last;
            fpga_msg_full = vecs[k].full;
            for (int i = 0; i < N; i++) lane[i] = vecs[k].data | (W'(i) << 24);
            #1;
            check($sformatf("%s[%0d] ack", tag, k), W'(req_ack), W'(vecs[k].e_ack));
            check($sformatf("%s[%0d] msg_valid", tag, k), W'(fpga_msg_valid), W'(vecs[k].e_mv));
            check($sformatf("%s[%0d] msg", tag, k), fpga_msg, vecs[k].e_msg);
            check($sformatf("%s[%0d] grant", tag, k), W'(grant_id), W'(vecs[k].e_grant));
            check($sformatf("%s[%0d] busy", tag, k), W'(busy), W'(vecs[k].e_busy));
        end
        vecs.delete();
    endtask

    task automatic monitor(input string tag);
        logic [W-1:0] e;
        if (fpga_msg_valid) begin
            if (exp_q.size() == 0) begin
                check({tag, " extra word"}, fpga_msg, 32'hDEAD_BEEF);
            end else begin
                e = exp_q.pop_front();
                check({tag, " word"}, fpga_msg, e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        clear_inputs();
        #2 rst_n = 1'b0;
        #1;
        check("rst msg_valid", W'(fpga_msg_valid), 0);
        check("rst msg", fpga_msg, 0);
        check("rst ack", W'(req_ack), 0);
        check("rst grant", W'(grant_id), 0);
        check("rst busy", W'(busy), 0);
        check("rst ovf", W'(overflow_err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single requester 1, then lock hold while grantee withdraws valid.
        add(4'b0010, 4'b0000, 0, 32'hA1, 4'b0000, 0, 32'h0,         2'd0, 0);
        add(4'b0010, 4'b0000, 0, 32'hA1, 4'b0010, 0, 32'h0,         2'd1, 1);
        add(4'b0010, 4'b0000, 0, 32'hA2, 4'b0010, 1, 32'h0100_00A1, 2'd1, 1);
        add(4'b0010, 4'b0010, 0, 32'hA3, 4'b0010, 1, 32'h0100_00A2, 2'd1, 1);
        add(4'b0000, 4'b0000, 0, 32'h00, 4'b0000, 1, 32'h0100_00A3, 2'd1, 0);
        add(4'b0010, 4'b0000, 0, 32'hB1, 4'b0000, 0, 32'h0100_00A3, 2'd1, 0);
        add(4'b0010, 4'b0000, 0, 32'hB1, 4'b0010, 0, 32'h0100_00A3, 2'd1, 1);
        add(4'b0001, 4'b0000, 0, 32'hC0, 4'b0000, 1, 32'h0100_00B1, 2'd1, 1);
        add(4'b0001, 4'b0000, 0, 32'hC0, 4'b0000, 0, 32'h0100_00B1, 2'd1, 1);
        add(4'b0011, 4'b0011, 0, 32'hB2, 4'b0010, 0, 32'h0100_00B1, 2'd1, 1);
        add(4'b0001, 4'b0001, 0, 32'hC0, 4'b0000, 1, 32'h0100_00B2, 2'd1, 0);
        add(4'b0001, 4'b0001, 0, 32'hC0, 4'b0001, 0, 32'h0100_00B2, 2'd0, 1);
        add(4'b0000, 4'b0000, 0, 32'h00, 4'b0000, 1, 32'h0000_00C0, 2'd0, 0);
        run_vecs("single");

        // Requesters 0 and 2 contend; order 0,0,2,2 then alternating grants.
        do_reset();
        add(4'b0101, 4'b0000, 0, 32'hD1, 4'b0000, 0, 32'h0,         2'd0, 0);
        add(4'b0101, 4'b0000, 0, 32'hD1, 4'b0001, 0, 32'h0,         2'd0, 1);
        add(4'b0101, 4'b0101, 0, 32'hD2, 4'b0001, 1, 32'h0000_00D1, 2'd0, 1);
        add(4'b0100, 4'b0000, 0, 32'hD1, 4'b0000, 1, 32'h0000_00D2, 2'd0, 0);
        add(4'b0100, 4'b0000, 0, 32'hD1, 4'b0100, 0, 32'h0000_00D2, 2'd2, 1);
        add(4'b0100, 4'b0100, 0, 32'hD2, 4'b0100, 1, 32'h0200_00D1, 2'd2, 1);
        add(4'b0101, 4'b0000, 0, 32'hB3, 4'b0000, 1, 32'h0200_00D2, 2'd2, 0);
        add(4'b0101, 4'b0001, 0, 32'hB3, 4'b0001, 0, 32'h0200_00D2, 2'd0, 1);
        add(4'b0101, 4'b0100, 0, 32'hB4, 4'b0000, 1, 32'h0000_00B3, 2'd0, 0);
        add(4'b0101, 4'b0100, 0, 32'hB4, 4'b0100, 0, 32'h0000_00B3, 2'd2, 1);
        add(4'b0000, 4'b0000, 0, 32'h00, 4'b0000, 1, 32'h0200_00B4, 2'd2, 0);
        run_vecs("pair");

        // Requester 3 sends 20 words; requester 0 slots in after the 16-word burst.
        do_reset();
        for (int k = 0; k < 16; k++) exp_q.push_back(32'h3000_0000 + k);
        exp_q.push_back(32'h0000_00C0);
        for (int k = 16; k < 20; k++) exp_q.push_back(32'h3000_0000 + k);
        w3 = 0; done0 = 0; n3_before0 = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            req_valid[3] = (w3 < 20);
            req_last[3] = (w3 == 19);
            lane[3] = 32'h3000_0000 + w3;
            req_valid[0] = (cyc >= 1) && (done0 == 0);
            req_last[0] = 1'b1;
            lane[0] = 32'h0000_00C0;
            #1;
            monitor("burst");
            if (req_ack[3]) begin
                w3++;
                if (done0 == 0) n3_before0++;
            end
            if (req_ack[0]) done0 = 1;
        end
        check("burst words before req0", n3_before0, 16);
        check("burst req3 total", w3, 20);
        check("burst req0 served", done0, 1);
        check("burst leftover", exp_q.size(), 0);
        exp_q.delete();

        // Back-pressure: full for 5 cycles in the middle of an 8-word message.
        clear_inputs();
        for (int k = 0; k < 8; k++) exp_q.push_back(32'h1100_0000 + k);
        acks_total = 0; acks_in_full = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            fpga_msg_full = (cyc >= 5 && cyc < 10);
            req_valid[1] = (acks_total < 8);
            req_last[1] = (acks_total == 7);
            lane[1] = 32'h1100_0000 + acks_total;
            #1;
            monitor("full");
            if (req_ack[1]) begin
                acks_total++;
                if (fpga_msg_full) acks_in_full++;
            end
        end
        check("full acks during pulse", acks_in_full, 0);
        check("full acks total", acks_total, 8);
        check("full leftover", exp_q.size(), 0);
        exp_q.delete();

        // Sticky overflow.
        clear_inputs();
        @(negedge clk);
        #1 check("ovf before pulse", W'(overflow_err), 0);
        fpga_msg_overflow = 1'b1;
        @(negedge clk);
        fpga_msg_overflow = 1'b0;
        #1 check("ovf after pulse", W'(overflow_err), 1);
        repeat (5) @(negedge clk);
        #1 check("ovf sticky", W'(overflow_err), 1);

        // Reset after 2 of 4 words from requester 2 (last_grant is 1 here).
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid = 4'b0100;
            req_last = 4'b0000;
            lane[2] = 32'h2200_0000 + (c == 0 ? 0 : c - 1);
        end
        @(negedge clk);
        #1;
        check("mid busy", W'(busy), 1);
        check("mid grant", W'(grant_id), 2);
        check("mid msg", fpga_msg, 32'h2200_0001);
        #2 rst_n = 1'b0;
        #1;
        check("arst msg_valid", W'(fpga_msg_valid), 0);
        check("arst msg", fpga_msg, 0);
        check("arst ack", W'(req_ack), 0);
        check("arst grant", W'(grant_id), 0);
        check("arst busy", W'(busy), 0);
        check("arst ovf", W'(overflow_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b0111;
        req_last = 4'b0111;
        lane[0] = 32'h0000_00E0;
        @(negedge clk);
        #1;
        check("post-rst busy", W'(busy), 1);
        check("post-rst grant", W'(grant_id), 0);
        check("post-rst ack", W'(req_ack), 4'b0001);
        clear_inputs();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
